// File: rtl/lsu_dmem_ctrl.sv
// ============================================================================
// lsu_dmem_ctrl - MEM-stage load/store unit: valid/ready data-memory requests,
// store lane steering, load extract/extend, pipeline stall.   Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_dmem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wr_data_i,
  output logic              dmem_req_o,
  input  logic              dmem_ready_i,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_wstrb_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       ld_data_o,
  output logic              stall_o,
  output logic              misaligned_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         ld_data_q, ld_data_d;

  logic                w_access;
  logic                w_size_byte;
  logic                w_size_half;
  logic                w_misaligned;
  logic [3:0]          w_wstrb;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rd_shift;
  logic [31:0]         w_ld_ext;

  assign w_access    = mem_rd_en_i | mem_wr_en_i;
  // funct3[1:0] carries the access size; 2'b11 falls into the word class.
  assign w_size_byte = (funct3_i[1:0] == 2'b00);
  assign w_size_half = (funct3_i[1:0] == 2'b01);

  always_comb begin
    w_misaligned = 1'b0;
    if (w_size_half) begin
      w_misaligned = addr_i[0];
    end else if (!w_size_byte) begin
      w_misaligned = (addr_i[1:0] != 2'b00);
    end
  end

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = wr_data_i;
    if (w_size_byte) begin
      w_wstrb = 4'b0001 << addr_i[1:0];
      w_wdata = {4{wr_data_i[7:0]}};
    end else if (w_size_half) begin
      w_wstrb = 4'b0011 << addr_i[1:0];
      w_wdata = {2{wr_data_i[15:0]}};
    end
  end

  assign w_rd_shift = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    w_ld_ext = dmem_rdata_i;
    case (funct3_q)
      3'b000:  w_ld_ext = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
      3'b100:  w_ld_ext = {24'd0, w_rd_shift[7:0]};
      3'b001:  w_ld_ext = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
      3'b101:  w_ld_ext = {16'd0, w_rd_shift[15:0]};
      default: w_ld_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    ld_data_d = ld_data_q;
    case (state_q)
      IDLE: begin
        if (w_access && !w_misaligned) begin
          we_d     = mem_wr_en_i;
          addr_d   = {addr_i[ADDR_W-1:2], 2'b00};
          wstrb_d  = mem_wr_en_i ? w_wstrb : 4'b0000;
          wdata_d  = w_wdata;
          funct3_d = funct3_i;
          off_d    = addr_i[1:0];
          state_d  = REQ;
        end
      end
      REQ: begin
        if (dmem_ready_i) begin
          state_d = we_q ? DONE : RSP;
        end
      end
      RSP: begin
        if (dmem_rvalid_i) begin
          ld_data_d = w_ld_ext;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= 4'b0000;
      wdata_q   <= 32'd0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      ld_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wstrb_o = wstrb_q;
  assign dmem_wdata_o = wdata_q;
  assign ld_data_o    = ld_data_q;
  // DONE is the single cycle that lets the pipeline advance past the access.
  assign stall_o      = w_access & ~w_misaligned & (state_q != DONE);
  assign misaligned_o = w_access & w_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
// ============================================================================
// tb_lsu_dmem_ctrl - directed self-checking bench for lsu_dmem_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_rd_en_i;
  logic        mem_wr_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        dmem_req_o;
  logic        dmem_ready_i;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] ld_data_o;
  logic        stall_o;
  logic        misaligned_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_ld;

  lsu_dmem_ctrl #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd_en_i   (mem_rd_en_i),
    .mem_wr_en_i   (mem_wr_en_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wr_data_i     (wr_data_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_ready_i  (dmem_ready_i),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wstrb_o  (dmem_wstrb_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .ld_data_o     (ld_data_o),
    .stall_o       (stall_o),
    .misaligned_o  (misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_rd_en_i   = 1'b0;
    mem_wr_en_i   = 1'b0;
    funct3_i      = 3'd0;
    addr_i        = 32'd0;
    wr_data_i     = 32'd0;
    dmem_ready_i  = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'd0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, stall_o, misaligned_o} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {dmem_req_o, dmem_we_o, dmem_wstrb_o, stall_o, misaligned_o});
    end
    n_cmp++;
    if ({dmem_addr_o, dmem_wdata_o, ld_data_o} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wdata=%h ld=%h want all 0",
               dmem_addr_o, dmem_wdata_o, ld_data_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_ext();
    logic [2:0]  t_f3   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b100};
    logic [31:0] t_addr [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1001};
    logic [31:0] t_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AA,
                                32'hFFFF_80AA, 32'h80AA_BBCC, 32'h0000_00BB};
    for (int i = 0; i < 6; i++) begin
      mem_rd_en_i = 1'b1;
      funct3_i    = t_f3[i];
      addr_i      = t_addr[i];
      #1;
      n_cmp++;
      if ({stall_o, dmem_req_o, misaligned_o} !== 3'b100) begin
        n_err++;
        $display("FAIL load%0d_idle: got stall/req/mis=%b want 100", i,
                 {stall_o, dmem_req_o, misaligned_o});
      end
      step();
      n_cmp++;
      if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o} !== {1'b1, 1'b0, 4'b0000, 32'h1000}) begin
        n_err++;
        $display("FAIL load%0d_req: got req=%b we=%b wstrb=%b addr=%h want 1 0 0000 00001000",
                 i, dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o);
      end
      dmem_ready_i = 1'b1;
      step();
      dmem_ready_i = 1'b0;
      n_cmp++;
      if ({dmem_req_o, stall_o} !== 2'b01) begin
        n_err++;
        $display("FAIL load%0d_rsp: got req/stall=%b want 01", i, {dmem_req_o, stall_o});
      end
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h80AA_BBCC;
      step();
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h5555_5555;
      n_cmp++;
      if ({stall_o, ld_data_o} !== {1'b0, t_exp[i]}) begin
        n_err++;
        $display("FAIL load%0d_done: got stall=%b ld=%h want 0 %h", i, stall_o, ld_data_o, t_exp[i]);
      end
      mem_rd_en_i = 1'b0;
      step();
      n_cmp++;
      if (ld_data_o !== t_exp[i]) begin
        n_err++;
        $display("FAIL load%0d_hold: got ld=%h want %h", i, ld_data_o, t_exp[i]);
      end
      exp_ld = t_exp[i];
    end
  endtask

  task automatic test_store();
    logic [2:0]  t_f3    [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] t_addr  [3] = '{32'h2002, 32'h2001, 32'h2004};
    logic [31:0] t_wd    [3] = '{32'h1234_ABCD, 32'h0000_00EF, 32'hCAFE_F00D};
    logic [3:0]  t_strb  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] t_wdata [3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hCAFE_F00D};
    logic [31:0] t_waddr [3] = '{32'h2000, 32'h2000, 32'h2004};
    for (int i = 0; i < 3; i++) begin
      mem_wr_en_i = 1'b1;
      funct3_i    = t_f3[i];
      addr_i      = t_addr[i];
      wr_data_i   = t_wd[i];
      #1;
      n_cmp++;
      if ({stall_o, misaligned_o, dmem_req_o} !== 3'b100) begin
        n_err++;
        $display("FAIL store%0d_idle: got stall/mis/req=%b want 100", i,
                 {stall_o, misaligned_o, dmem_req_o});
      end
      step();
      n_cmp++;
      if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o} !==
          {1'b1, 1'b1, t_strb[i], t_waddr[i], t_wdata[i]}) begin
        n_err++;
        $display("FAIL store%0d_req: got req=%b we=%b wstrb=%b addr=%h wdata=%h want 1 1 %b %h %h",
                 i, dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o,
                 t_strb[i], t_waddr[i], t_wdata[i]);
      end
      dmem_ready_i = 1'b1;
      step();
      dmem_ready_i = 1'b0;
      n_cmp++;
      if ({stall_o, dmem_req_o, ld_data_o} !== {1'b0, 1'b0, exp_ld}) begin
        n_err++;
        $display("FAIL store%0d_done: got stall=%b req=%b ld=%h want 0 0 %h",
                 i, stall_o, dmem_req_o, ld_data_o, exp_ld);
      end
      mem_wr_en_i = 1'b0;
      step();
    end
  endtask

  task automatic test_wait_states();
    int stall_cnt = 0;
    mem_wr_en_i = 1'b1;
    funct3_i    = 3'b010;
    addr_i      = 32'h4008;
    wr_data_i   = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (stall_o === 1'b1) stall_cnt++;
      if (i >= 1) begin
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o} !==
            {1'b1, 1'b1, 4'b1111, 32'h4008, 32'hDEAD_BEEF}) begin
          n_err++;
          $display("FAIL wait_hold%0d: got req=%b we=%b wstrb=%b addr=%h wdata=%h want 1 1 1111 00004008 deadbeef",
                   i, dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o);
        end
      end
      if (i == 4) dmem_ready_i = 1'b1;
      step();
    end
    dmem_ready_i = 1'b0;
    n_cmp++;
    if ({stall_o, dmem_req_o} !== 2'b00) begin
      n_err++;
      $display("FAIL wait_done: got stall/req=%b want 00", {stall_o, dmem_req_o});
    end
    n_cmp++;
    if (stall_cnt !== 5) begin
      n_err++;
      $display("FAIL wait_stall_cycles: got %0d want 5", stall_cnt);
    end
    mem_wr_en_i = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    logic        t_rd   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  t_f3   [4] = '{3'b010, 3'b101, 3'b010, 3'b001};
    logic [31:0] t_addr [4] = '{32'h3001, 32'h3003, 32'h3002, 32'h3001};
    for (int i = 0; i < 4; i++) begin
      mem_rd_en_i = t_rd[i];
      mem_wr_en_i = ~t_rd[i];
      funct3_i    = t_f3[i];
      addr_i      = t_addr[i];
      #1;
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if ({misaligned_o, stall_o, dmem_req_o} !== 3'b100) begin
          n_err++;
          $display("FAIL misaligned%0d_c%0d: got mis/stall/req=%b want 100", i, c,
                   {misaligned_o, stall_o, dmem_req_o});
        end
        step();
      end
      idle_inputs();
      step();
    end
  endtask

  task automatic test_reset_mid();
    mem_rd_en_i = 1'b1;
    funct3_i    = 3'b010;
    addr_i      = 32'h3004;
    step();
    dmem_ready_i = 1'b1;
    step();
    dmem_ready_i = 1'b0;
    n_cmp++;
    if ({dmem_req_o, stall_o} !== 2'b01) begin
      n_err++;
      $display("FAIL rstmid_rsp: got req/stall=%b want 01", {dmem_req_o, stall_o});
    end
    rst = 1'b1;
    idle_inputs();
    step();
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, stall_o, misaligned_o} !== 8'b0) begin
      n_err++;
      $display("FAIL rstmid_ctrl: got %b want 00000000",
               {dmem_req_o, dmem_we_o, dmem_wstrb_o, stall_o, misaligned_o});
    end
    n_cmp++;
    if ({dmem_addr_o, dmem_wdata_o, ld_data_o} !== 96'd0) begin
      n_err++;
      $display("FAIL rstmid_data: got addr=%h wdata=%h ld=%h want all 0",
               dmem_addr_o, dmem_wdata_o, ld_data_o);
    end
    rst = 1'b0;
    step();
    mem_rd_en_i = 1'b1;
    funct3_i    = 3'b010;
    addr_i      = 32'h3004;
    step();
    n_cmp++;
    if ({dmem_req_o, dmem_addr_o} !== {1'b1, 32'h3004}) begin
      n_err++;
      $display("FAIL rstmid_relw_req: got req=%b addr=%h want 1 00003004", dmem_req_o, dmem_addr_o);
    end
    dmem_ready_i = 1'b1;
    step();
    dmem_ready_i  = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1122_3344;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++;
    if ({stall_o, ld_data_o} !== {1'b0, 32'h1122_3344}) begin
      n_err++;
      $display("FAIL rstmid_relw_done: got stall=%b ld=%h want 0 11223344", stall_o, ld_data_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    mem_rd_en_i = 1'b1;
    funct3_i    = 3'b010;
    addr_i      = 32'h5000;
    step();
    dmem_ready_i = 1'b1;
    step();
    dmem_ready_i  = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hA5A5_0001;
    step();
    dmem_rvalid_i = 1'b0;
    mem_rd_en_i   = 1'b0;
    mem_wr_en_i   = 1'b1;
    funct3_i      = 3'b000;
    addr_i        = 32'h5003;
    wr_data_i     = 32'h0000_0077;
    #1;
    n_cmp++;
    if ({stall_o, ld_data_o} !== {1'b0, 32'hA5A5_0001}) begin
      n_err++;
      $display("FAIL b2b_done: got stall=%b ld=%h want 0 a5a50001", stall_o, ld_data_o);
    end
    step();
    n_cmp++;
    if ({dmem_req_o, stall_o} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_idle: got req/stall=%b want 01", {dmem_req_o, stall_o});
    end
    step();
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o} !==
        {1'b1, 1'b1, 4'b1000, 32'h5000, 32'h7777_7777}) begin
      n_err++;
      $display("FAIL b2b_req: got req=%b we=%b wstrb=%b addr=%h wdata=%h want 1 1 1000 00005000 77777777",
               dmem_req_o, dmem_we_o, dmem_wstrb_o, dmem_addr_o, dmem_wdata_o);
    end
    dmem_ready_i = 1'b1;
    step();
    dmem_ready_i = 1'b0;
    n_cmp++;
    if ({stall_o, ld_data_o} !== {1'b0, 32'hA5A5_0001}) begin
      n_err++;
      $display("FAIL b2b_store_done: got stall=%b ld=%h want 0 a5a50001", stall_o, ld_data_o);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    rst    = 1'b1;
    exp_ld = 32'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_ext();
    test_store();
    test_wait_states();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
